// File: rtl/avmm_mem_responder.sv
// Avalon-MM responder memory: fixed READ_LATENCY read pipeline, byte-enabled writes, no stalls.
// Optional out-of-range checking when AVMM_MEM_OOR_CHECK_EN is defined (otherwise addresses wrap).
module avmm_mem_responder #(
    parameter int DEPTH_LOG2   = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [63:0] avs_address,
    input  logic [7:0]  avs_byteenable,
    input  logic        avs_read,
    output logic [63:0] avs_readdata,
    input  logic        avs_write,
    input  logic [63:0] avs_writedata,
    output logic        avs_readdatavalid,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic        proto_err,
    output logic        oor_err
);
    localparam int          DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [63:0] OOR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

    logic [63:0]           mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  oor;
    logic                  rd_fire;
    logic                  mem_wr;
    logic                  unused_addr;

    assign word_idx = avs_address[DEPTH_LOG2+2:3];

`ifdef AVMM_MEM_OOR_CHECK_EN
    assign oor         = |avs_address[63:DEPTH_LOG2+3];
    assign unused_addr = ^avs_address[2:0];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            oor_err <= 1'b0;
        else if ((avs_read || avs_write) && oor)
            oor_err <= 1'b1;
    end
`else
    assign oor         = 1'b0;
    assign oor_err     = 1'b0;
    assign unused_addr = ^{avs_address[63:DEPTH_LOG2+3], avs_address[2:0]};
`endif

    // A read colliding with a write is dropped; the write still goes through.
    assign rd_fire = avs_read && !avs_write;
    assign mem_wr  = avs_write && !oor;

    // Array is deliberately not reset so it maps onto block RAM and survives resetn.
    always_ff @(posedge clock) begin
        if (mem_wr) begin
            for (int b = 0; b < 8; b++) begin
                if (avs_byteenable[b])
                    mem[word_idx][8*b +: 8] <= avs_writedata[8*b +: 8];
            end
        end
    end

    logic [READ_LATENCY-1:0] pipe_vld;
    logic [63:0]             pipe_dat [READ_LATENCY];

    // Stage data only advances behind a valid, so the last stage holds the previous response.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pipe_vld <= '0;
            for (int k = 0; k < READ_LATENCY; k++)
                pipe_dat[k] <= '0;
        end else begin
            pipe_vld[0] <= rd_fire;
            if (rd_fire)
                pipe_dat[0] <= oor ? OOR_DATA : mem[word_idx];
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                if (pipe_vld[k-1])
                    pipe_dat[k] <= pipe_dat[k-1];
            end
        end
    end

    assign avs_readdatavalid = pipe_vld[READ_LATENCY-1];
    assign avs_readdata      = pipe_dat[READ_LATENCY-1];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_count  <= '0;
            wr_count  <= '0;
            proto_err <= 1'b0;
        end else begin
            if (rd_fire)
                rd_count <= rd_count + 32'd1;
            if (avs_write)
                wr_count <= wr_count + 32'd1;
            if (avs_read && avs_write)
                proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_avmm_mem_responder.sv
// Bench for avmm_mem_responder: latency-1 and latency-3 instances driven in lockstep
// against a word-array/response-queue reference model.
module tb_avmm_mem_responder;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [63:0] avs_address = '0;
    logic [7:0]  avs_byteenable = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [63:0] avs_writedata = '0;

    logic [63:0] rdata1, rdata3;
    logic        rvld1, rvld3;
    logic [31:0] rdc1, rdc3, wrc1, wrc3;
    logic        perr1, perr3, oerr1, oerr3;

    always #5 clock = ~clock;

    avmm_mem_responder #(.DEPTH_LOG2(12), .READ_LATENCY(1)) dut1 (
        .clock(clock), .resetn(resetn), .avs_address(avs_address),
        .avs_byteenable(avs_byteenable), .avs_read(avs_read), .avs_readdata(rdata1),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdatavalid(rvld1),
        .rd_count(rdc1), .wr_count(wrc1), .proto_err(perr1), .oor_err(oerr1));

    avmm_mem_responder #(.DEPTH_LOG2(12), .READ_LATENCY(3)) dut3 (
        .clock(clock), .resetn(resetn), .avs_address(avs_address),
        .avs_byteenable(avs_byteenable), .avs_read(avs_read), .avs_readdata(rdata3),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdatavalid(rvld3),
        .rd_count(rdc3), .wr_count(wrc3), .proto_err(perr3), .oor_err(oerr3));

    typedef struct packed {
        logic [31:0] due;
        logic [63:0] dat;
    } rsp_t;

    logic [63:0] mm [0:4095];
    rsp_t        q1[$];
    rsp_t        q3[$];
    logic [63:0] last1, last3;
    int unsigned mrd, mwr;
    logic        mperr, moerr;
    int unsigned edge_n;
    int          tests;
    int          fails;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_oor(input logic [63:0] a);
`ifdef AVMM_MEM_OOR_CHECK_EN
        return a >= 64'h8000;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int widx(input logic [63:0] a);
        return int'((a % 64'h8000) / 64'd8);
    endfunction

    task automatic check_outputs();
        if (q1.size() > 0 && q1[0].due == edge_n) begin
            chk("vld_l1", rvld1, 1);
            chk("dat_l1", rdata1, q1[0].dat);
            last1 = q1[0].dat;
            void'(q1.pop_front());
        end else begin
            chk("idle_vld_l1", rvld1, 0);
            chk("hold_dat_l1", rdata1, last1);
        end
        if (q3.size() > 0 && q3[0].due == edge_n) begin
            chk("vld_l3", rvld3, 1);
            chk("dat_l3", rdata3, q3[0].dat);
            last3 = q3[0].dat;
            void'(q3.pop_front());
        end else begin
            chk("idle_vld_l3", rvld3, 0);
            chk("hold_dat_l3", rdata3, last3);
        end
        chk("rd_count_l1", rdc1, mrd);
        chk("wr_count_l1", wrc1, mwr);
        chk("rd_count_l3", rdc3, mrd);
        chk("wr_count_l3", wrc3, mwr);
        chk("proto_err", perr1, mperr);
        chk("oor_err", oerr1, moerr);
    endtask

    task automatic step(input logic rd, input logic wr, input logic [63:0] a,
                        input logic [7:0] be, input logic [63:0] d);
        rsp_t r;
        avs_read = rd; avs_write = wr; avs_address = a;
        avs_byteenable = be; avs_writedata = d;
        @(posedge clock);
        edge_n++;
        if (rd && wr) begin
            mperr = 1'b1;
        end else if (rd) begin
            r.dat = is_oor(a) ? 64'hDEAD_BEEF_DEAD_BEEF : mm[widx(a)];
            r.due = edge_n;
            q1.push_back(r);
            r.due = edge_n + 2;
            q3.push_back(r);
            mrd++;
        end
        if (wr) begin
            mwr++;
            if (!is_oor(a))
                for (int b = 0; b < 8; b++)
                    if (be[b]) mm[widx(a)][8*b +: 8] = d[8*b +: 8];
        end
        if ((rd || wr) && is_oor(a))
            moerr = 1'b1;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 64'h0, 8'h00, 64'h0);
    endtask

    // Asserts reset between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        avs_read = 1'b0; avs_write = 1'b0;
        resetn = 1'b0;
        #1;
        q1.delete(); q3.delete();
        last1 = '0; last3 = '0;
        mrd = 0; mwr = 0; mperr = 1'b0; moerr = 1'b0;
        chk("rst_vld_l1", rvld1, 0);
        chk("rst_vld_l3", rvld3, 0);
        chk("rst_dat_l1", rdata1, 0);
        chk("rst_dat_l3", rdata3, 0);
        chk("rst_rd_count", rdc1, 0);
        chk("rst_wr_count", wrc3, 0);
        chk("rst_proto_err", perr1, 0);
        chk("rst_oor_err", oerr3, 0);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        logic [63:0] w0, w1, w2, a;
        logic        rd, wr;
        int          op;
        tests = 0; fails = 0; edge_n = 0;
        for (int i = 0; i < 4096; i++) mm[i] = '0;

        do_reset();
        for (int w = 0; w < 16; w++)
            step(0, 1, 64'(w * 8), 8'hFF, {$urandom, $urandom});
        do_reset();

        // Full write then read, latency 1
        step(0, 1, 64'h40, 8'hFF, 64'h0123_4567_89AB_CDEF);
        step(1, 0, 64'h40, 8'h00, 64'h0);
        chk("t1_data", rdata1, 64'h0123_4567_89AB_CDEF);
        chk("t1_vld", rvld1, 1);
        chk("t1_wr_count", wrc1, 1);
        chk("t1_rd_count", rdc1, 1);
        idle(3);

        // Partial byte enables; low address bits ignored
        step(0, 1, 64'h08, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        step(0, 1, 64'h08, 8'h0F, 64'h0);
        step(1, 0, 64'h08, 8'h00, 64'h0);
        chk("be_data", rdata1, 64'hFFFF_FFFF_0000_0000);
        step(1, 0, 64'h0F, 8'h00, 64'h0);
        chk("lowbits_data", rdata1, 64'hFFFF_FFFF_0000_0000);
        idle(3);

        // Back-to-back reads through the latency-3 pipeline
        w0 = mm[0]; w1 = mm[1]; w2 = mm[2];
        step(1, 0, 64'h00, 8'h00, 64'h0);
        chk("l3_early", rvld3, 0);
        step(1, 0, 64'h08, 8'h00, 64'h0);
        step(1, 0, 64'h10, 8'h00, 64'h0);
        chk("l3_first", rdata3, w0);
        idle(1);
        chk("l3_second", rdata3, w1);
        idle(1);
        chk("l3_third", rdata3, w2);
        idle(1);
        chk("l3_done", rvld3, 0);

        // Read+write collision
        step(1, 1, 64'h18, 8'hFF, 64'h55);
        chk("coll_proto_err", perr1, 1);
        chk("coll_no_vld", rvld1, 0);
        idle(3);
        step(1, 0, 64'h18, 8'h00, 64'h0);
        chk("coll_wr_data", rdata1, 64'h55);
        chk("coll_sticky", perr3, 1);
        idle(3);

        // Reset with a read still in flight in the latency-3 instance
        step(1, 0, 64'h40, 8'h00, 64'h0);
        do_reset();
        idle(4);
        step(1, 0, 64'h18, 8'h00, 64'h0);
        chk("survive_data", rdata1, 64'h55);
        idle(3);

        // High address bits: aliasing or out-of-range depending on build
        w0 = mm[0];
        step(0, 1, 64'h8000, 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5);
        step(1, 0, 64'h0, 8'h00, 64'h0);
`ifdef AVMM_MEM_OOR_CHECK_EN
        chk("oor_word0_kept", rdata1, w0);
        step(1, 0, 64'h8000, 8'h00, 64'h0);
        chk("oor_data", rdata1, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("oor_flag", oerr1, 1);
`else
        chk("alias_word0", rdata1, 64'hA5A5_A5A5_A5A5_A5A5);
        step(1, 0, 64'h8000, 8'h00, 64'h0);
        chk("alias_read", rdata1, 64'hA5A5_A5A5_A5A5_A5A5);
        chk("alias_no_oor", oerr1, 0);
`endif
        idle(3);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 19);
            rd = (op < 8) || (op == 19);
            wr = (op >= 8 && op < 16) || (op == 19);
            a  = 64'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0)
                a = a | (64'h1 << $urandom_range(15, 63));
            step(rd, wr, a, 8'($urandom), {$urandom, $urandom});
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/avmm_mem_responder.md
Name: avmm_mem_responder

Overview:
- Avalon-MM responder (slave) memory that serves an HLS component's avmm_*_rw master port, e.g. the dijkstra graph/distance buffer.
- Matches the component master's wire set: address/byteenable/read/readdata/write/writedata, with no waitrequest and no master-side readdatavalid. It therefore answers reads at a fixed, parameterised latency and never stalls.
- Used as on-chip backing store in system builds and as the memory model in component benches.

Parameters:
DEPTH_LOG2, 12, log2 of the number of 64-bit words stored (4096 words = 32 KiB).
READ_LATENCY, 1, cycles from read accept to readdata/avs_readdatavalid; legal range 1..8.

Ports:
clock  in  1  system clock
resetn  in  1  reset, asynchronous assert, active-low
avs_address  in  64  byte address from master; word index = avs_address[DEPTH_LOG2+2:3]
avs_byteenable  in  8  per-byte write enable; bit i covers writedata[8i+7:8i]
avs_read  in  1  read request, accepted every cycle it is high
avs_readdata  out  64  read response data
avs_write  in  1  write request, accepted every cycle it is high
avs_writedata  in  64  write data
avs_readdatavalid  out  1  sideband strobe marking avs_readdata valid (bench/debug use)
rd_count  out  32  number of reads accepted
wr_count  out  32  number of writes accepted
proto_err  out  1  sticky flag: read and write asserted in the same cycle
oor_err  out  1  sticky out-of-range flag; only driven under the optional feature

Behaviour:
- Interface: one clock `clock`; reset `resetn` is asynchronous and active-low.
- Reset values: avs_readdata=0, avs_readdatavalid=0, rd_count=0, wr_count=0, proto_err=0, oor_err=0. The latency pipeline is cleared.
- Memory array contents are not reset and survive resetn.
- Addressing:
  - avs_address[2:0] are ignored; access is always a full aligned 64-bit word.
  - Bits above DEPTH_LOG2+2 are ignored, so the address wraps modulo depth unless AVMM_MEM_OOR_CHECK_EN is defined.
- Write: on the cycle avs_write=1, bytes with byteenable=1 are updated at the rising edge. byteenable=0x00 is a legal no-op write that still increments wr_count.
- Read: on the cycle avs_read=1 (cycle T), the word is sampled at the edge that ends T.
  - avs_readdata and avs_readdatavalid=1 are presented in cycle T+READ_LATENCY, for exactly 1 cycle.
  - Back-to-back reads are fully pipelined: one response per cycle, in order.
- avs_readdata holds its last returned value while avs_readdatavalid=0.
- Read-after-write: a read at T+1 of a word written at T returns the new data. No bypass is needed because the write completes at the end of T.
- Simultaneous read and write in one cycle (protocol violation):
  - The write is performed and wr_count increments.
  - The read is dropped: no response, rd_count unchanged.
  - proto_err sets and stays set until reset.
- Counters are 32-bit, increment by 1 per accepted access, and wrap 0xFFFFFFFF to 0 silently.
- Reset mid-operation: in-flight reads are discarded and avs_readdatavalid deasserts immediately (asynchronously). Writes already clocked in remain in memory.
- Pipeline: READ_LATENCY stages carrying {valid, data}. Stage 1 is the RAM read; the remaining stages are registers, so the array maps to block RAM.

Optional Feature:
- Macro: AVMM_MEM_OOR_CHECK_EN.
- Defined: an access is out of range if any avs_address bit [63:DEPTH_LOG2+3] is nonzero.
  - Out-of-range write: discarded, memory unchanged, wr_count still increments.
  - Out-of-range read: returns 64'hDEAD_BEEF_DEAD_BEEF with normal latency and valid strobe, and rd_count increments.
  - oor_err sets sticky.
- Undefined: high address bits are ignored (the address wraps) and oor_err is tied 0.

Test Plan:
- Reset, then write 0x0123456789ABCDEF at address 0x40 with byteenable 0xFF, then read 0x40 -> with READ_LATENCY=1, readdata=0x0123456789ABCDEF and readdatavalid=1 exactly 1 cycle after the read; wr_count=1, rd_count=1.
- Write 0xFFFFFFFFFFFFFFFF at 0x08 (be 0xFF), then 0x0 at 0x08 with be=0x0F, then read -> 0xFFFFFFFF00000000. Read of 0x0F (low bits ignored) -> same value.
- READ_LATENCY=3: reads of 0x00, 0x08, 0x10 on 3 consecutive cycles -> 3 consecutive valid responses starting 3 cycles after the first read, in order, no gaps.
- read=1 and write=1 same cycle at 0x18 with data 0x55 -> no readdatavalid response, proto_err=1, a later read of 0x18 returns 0x55; proto_err clears only on resetn.
- Issue a read, assert resetn=0 before its response -> readdatavalid never pulses and counters=0 after reset. Data written before the reset is still readable afterwards.
- With AVMM_MEM_OOR_CHECK_EN and DEPTH_LOG2=12: read 0x8000 -> 0xDEADBEEFDEADBEEF and oor_err=1; write to 0x8000 leaves word 0 unchanged. Without the macro, write to 0x8000 aliases to word 0.
